// File: rtl/bcd_pkg.sv
// Shared types and helpers for the iterative binary-to-BCD converter.
// Holds the FSM state enum, the BCD nibble type and the digit-count check.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    typedef logic [3:0] nibble_t;

    // log10(2) as a fixed-point ratio, good enough for any practical width
    localparam int LOG2_NUM = 30103;
    localparam int LOG2_DEN = 100000;

    // Decimal digits needed for the largest magnitude of a width-bit operand.
    // Signed operands reach 2^(width-1), which has the same digit count
    // as 2^(width-1)-1 because a power of two is never a power of ten.
    function automatic int digits_needed(input int width, input bit is_signed);
        int bits;
        bits = is_signed ? width - 1 : width;
        return (bits * LOG2_NUM + LOG2_DEN - 1) / LOG2_DEN;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit cell: adds 3 to a BCD digit of 5 or more
// so that the following left shift carries cleanly into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  nibble_t d,
    output nibble_t q
);

    // Pre-correct the digit before it is doubled by the shift
    always_comb begin
        q = d;
        if (d >= 4'd5) begin
            q = d + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_iter.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock,
// with valid/ready handshakes on both sides and optional signed input.
module bin_to_bcd_iter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg,
    output logic                  busy
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int BCD_W = 4 * DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIN_W-1:0] BIN_ONE  = BIN_W'(1);

    if (DIGITS < digits_needed(BIN_W, SIGNED != 0)) begin : g_digits_chk
        $error("bin_to_bcd_iter: DIGITS too small for BIN_W");
    end

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] opr;
    logic [BCD_W-1:0] dig;
    logic [BCD_W-1:0] adj;
    logic [BCD_W-1:0] dig_nxt;
    logic             neg;
    logic             in_neg;
    logic [BIN_W-1:0] mag;
    logic             unused_top;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (dig[4*g +: 4]),
            .q (adj[4*g +: 4])
        );
    end

    // The top bit of the adjusted digits shifts out; it is always zero
    // when DIGITS is large enough for the operand width.
    assign {unused_top, dig_nxt} = {adj, opr[BIN_W-1]};

    assign in_neg = (SIGNED != 0) && in_bin[BIN_W-1];
    assign mag    = in_neg ? (~in_bin + BIN_ONE) : in_bin;

    // Conversion FSM: capture, shift BIN_W times, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            opr       <= '0;
            dig       <= '0;
            neg       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_neg   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        opr      <= mag;
                        neg      <= in_neg;
                        dig      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    dig <= dig_nxt;
                    opr <= {opr[BIN_W-2:0], 1'b0};
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        out_bcd   <= dig_nxt;
                        out_neg   <= neg;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
